// File: rtl/bexkat1Def.sv
// Shared bexkat1 definitions: instruction type codes, field positions,
// the bubble word and the decoded-instruction record used by decode.
package bexkat1Def;

    localparam int          REG_W        = 4;
    localparam int          NREGS_DEF    = 16;
    localparam logic [63:0] NOP_WORD_DEF = 64'h0;

    localparam int TYPE_LSB = 28;
    localparam int OP_LSB   = 24;
    localparam int RA_LSB   = 20;
    localparam int RB_LSB   = 16;
    localparam int RC_LSB   = 12;
    localparam int IMM_LSB  = 1;
    localparam int IMM_W    = 15;
    localparam int LONG_BIT = 0;
    localparam int EXT_LSB  = 32;

    typedef enum logic [3:0] {
        T_INH    = 4'h0,
        T_PUSH   = 4'h1,
        T_POP    = 4'h2,
        T_CMP    = 4'h3,
        T_MOV    = 4'h4,
        T_INTU   = 4'h5,
        T_INT    = 4'h6,
        T_FPU    = 4'h7,
        T_FP     = 4'h8,
        T_ALU    = 4'h9,
        T_LOAD   = 4'hA,
        T_STORE  = 4'hB,
        T_BRANCH = 4'hC,
        T_JUMP   = 4'hD,
        T_RSV_E  = 4'hE,
        T_RSV_F  = 4'hF
    } insn_type_t;

    typedef struct packed {
        insn_type_t       typ;
        logic [3:0]       op;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic             long_f;
    } decoded_t;

    // Types whose ra field is a source operand rather than a destination.
    function automatic logic reads_ra(input insn_type_t typ);
        case (typ)
            T_CMP, T_STORE, T_PUSH: reads_ra = 1'b1;
            default:                reads_ra = 1'b0;
        endcase
    endfunction

    function automatic decoded_t decode(input logic [31:0] w);
        decoded_t d;
        d.typ    = insn_type_t'(w[TYPE_LSB +: 4]);
        d.op     = w[OP_LSB +: 4];
        d.ra     = w[RA_LSB +: REG_W];
        d.rb     = w[RB_LSB +: REG_W];
        d.rc     = w[RC_LSB +: REG_W];
        d.long_f = w[LONG_BIT];
        return d;
    endfunction

endpackage

// File: rtl/idecode_regfile.sv
// Register file for decode: NREGS x 32, one write port, three async read ports.
// Macro IDECODE_WB_BYPASS_EN enables same-cycle write-through on the read ports.
module regfile
    import bexkat1Def::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [REG_W-1:0] i_wadr,
    input  logic [31:0]      i_wdat,
    input  logic [REG_W-1:0] i_adr_a,
    input  logic [REG_W-1:0] i_adr_b,
    input  logic [REG_W-1:0] i_adr_c,
    output logic [31:0]      o_dat_a,
    output logic [31:0]      o_dat_b,
    output logic [31:0]      o_dat_c
);

    logic [31:0] r_regs [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (i_we) begin
            r_regs[i_wadr] <= i_wdat;
        end
    end

`ifdef IDECODE_WB_BYPASS_EN
    assign o_dat_a = (i_we && (i_wadr == i_adr_a)) ? i_wdat : r_regs[i_adr_a];
    assign o_dat_b = (i_we && (i_wadr == i_adr_b)) ? i_wdat : r_regs[i_adr_b];
    assign o_dat_c = (i_we && (i_wadr == i_adr_c)) ? i_wdat : r_regs[i_adr_c];
`else
    assign o_dat_a = r_regs[i_adr_a];
    assign o_dat_b = r_regs[i_adr_b];
    assign o_dat_c = r_regs[i_adr_c];
`endif

endmodule

// File: rtl/idecode.sv
// bexkat1 decode stage: field/immediate decode, register read, load-use stall
// and the decode/execute pipeline register. See regfile for IDECODE_WB_BYPASS_EN.
module idecode
    import bexkat1Def::*;
#(
    parameter int          NREGS    = NREGS_DEF,
    parameter logic [63:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [63:0]      ir_i,
    input  logic [31:0]      pc_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_adr,
    input  logic [31:0]      wb_dat,
    input  logic             exe_load,
    input  logic [REG_W-1:0] exe_dest,
    output logic [63:0]      ir_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      reg_a,
    output logic [31:0]      reg_b,
    output logic [31:0]      reg_c,
    output logic [31:0]      sval,
    output logic [31:0]      uval,
    output logic             stall_o
);

    decoded_t    w_dec;
    logic        w_unused_op;
    logic [31:0] w_rd_a;
    logic [31:0] w_rd_b;
    logic [31:0] w_rd_c;
    logic [31:0] w_sval;
    logic [31:0] w_uval;
    logic        w_haz;

    logic [63:0] r_ir;
    logic [31:0] r_pc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_c;
    logic [31:0] r_sval;
    logic [31:0] r_uval;

    assign w_dec       = decode(ir_i[31:0]);
    assign w_unused_op = ^w_dec.op;

    regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_we    (wb_we),
        .i_wadr  (wb_adr),
        .i_wdat  (wb_dat),
        .i_adr_a (w_dec.ra),
        .i_adr_b (w_dec.rb),
        .i_adr_c (w_dec.rc),
        .o_dat_a (w_rd_a),
        .o_dat_b (w_rd_b),
        .o_dat_c (w_rd_c)
    );

    // Long form replaces both immediates with the extension word.
    always_comb begin
        w_sval = {{(32-IMM_W){ir_i[IMM_LSB+IMM_W-1]}}, ir_i[IMM_LSB +: IMM_W]};
        w_uval = {{(32-IMM_W){1'b0}}, ir_i[IMM_LSB +: IMM_W]};
        if (w_dec.long_f) begin
            w_sval = ir_i[EXT_LSB +: 32];
            w_uval = ir_i[EXT_LSB +: 32];
        end
    end

    always_comb begin
        w_haz = exe_load && (ir_i != NOP_WORD) &&
                ((exe_dest == w_dec.rb) || (exe_dest == w_dec.rc) ||
                 ((exe_dest == w_dec.ra) && reads_ra(w_dec.typ)));
    end

    assign stall_o = rst_i && (stall_i || (w_haz && !flush_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ir   <= 64'h0;
            r_pc   <= 32'h0;
            r_a    <= 32'h0;
            r_b    <= 32'h0;
            r_c    <= 32'h0;
            r_sval <= 32'h0;
            r_uval <= 32'h0;
        end else if (flush_i) begin
            r_ir <= NOP_WORD;
        end else if (stall_i) begin
            r_ir <= r_ir;
        end else if (w_haz) begin
            r_ir <= NOP_WORD;
        end else begin
            r_ir   <= ir_i;
            r_pc   <= pc_i;
            r_a    <= w_rd_a;
            r_b    <= w_rd_b;
            r_c    <= w_rd_c;
            r_sval <= w_sval;
            r_uval <= w_uval;
        end
    end

    assign ir_o  = r_ir;
    assign pc_o  = r_pc;
    assign reg_a = r_a;
    assign reg_b = r_b;
    assign reg_c = r_c;
    assign sval  = r_sval;
    assign uval  = r_uval;

endmodule

// File: tb/tb_idecode.sv
// Scoreboard bench for idecode: directed vectors push expectations, a negedge
// monitor pops and compares stall_o and the registered outputs.
module tb_idecode;

    logic        clk_i;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        stall_i;
    logic        wb_we;
    logic [3:0]  wb_adr;
    logic [31:0] wb_dat;
    logic        exe_load;
    logic [3:0]  exe_dest;
    logic [63:0] ir_o;
    logic [31:0] pc_o;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] reg_c;
    logic [31:0] sval;
    logic [31:0] uval;
    logic        stall_o;

    idecode dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ir_i     (ir_i),
        .pc_i     (pc_i),
        .flush_i  (flush_i),
        .stall_i  (stall_i),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat   (wb_dat),
        .exe_load (exe_load),
        .exe_dest (exe_dest),
        .ir_o     (ir_o),
        .pc_o     (pc_o),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .reg_c    (reg_c),
        .sval     (sval),
        .uval     (uval),
        .stall_o  (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall;
        logic [63:0] ir;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] s;
        logic [31:0] u;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef IDECODE_WB_BYPASS_EN
    localparam logic [31:0] BYP_A = 32'hA5A5A5A5;
`else
    localparam logic [31:0] BYP_A = 32'h0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Monitor: outputs are compared mid-cycle, away from the rising edge.
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("stall_o", {63'h0, stall_o}, {63'h0, e.stall});
            check("ir_o",    ir_o,            e.ir);
            check("pc_o",    {32'h0, pc_o},   {32'h0, e.pc});
            check("reg_a",   {32'h0, reg_a},  {32'h0, e.a});
            check("reg_b",   {32'h0, reg_b},  {32'h0, e.b});
            check("reg_c",   {32'h0, reg_c},  {32'h0, e.c});
            check("sval",    {32'h0, sval},   {32'h0, e.s});
            check("uval",    {32'h0, uval},   {32'h0, e.u});
        end
    end

    task automatic drive(input logic rst, input logic [63:0] ir, input logic [31:0] pc,
                         input logic ld, input logic [3:0] dest, input logic fl,
                         input logic st, input logic we, input logic [3:0] adr,
                         input logic [31:0] dat);
        rst_i    = rst;
        ir_i     = ir;
        pc_i     = pc;
        exe_load = ld;
        exe_dest = dest;
        flush_i  = fl;
        stall_i  = st;
        wb_we    = we;
        wb_adr   = adr;
        wb_dat   = dat;
    endtask

    // Expectation: stall_o for the inputs just driven, registered outputs as of now.
    task automatic step(input logic s, input logic [63:0] eir, input logic [31:0] epc,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                        input logic [31:0] es, input logic [31:0] eu);
        exp_t e;
        e.stall = s;
        e.ir    = eir;
        e.pc    = epc;
        e.a     = ea;
        e.b     = eb;
        e.c     = ec;
        e.s     = es;
        e.u     = eu;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 64'h0, 32'h0, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        @(posedge clk_i);
        #1;
        // reset: stall forced low, writes ignored
        drive(0, 64'h90015000, 32'h50, 1, 4'd5, 0, 1, 1, 4'd3, 32'hFFFF);
        step(0, 64'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 64'h0, 32'h0, 0, 4'd0, 0, 0, 1, 4'd3, 32'h1234);
        step(0, 64'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 64'h91230000, 32'h100, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 64'h9210FFFE, 32'h104, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h91230000, 32'h100, 0, 32'h1234, 0, 0, 0);
        drive(1, 64'hDEADBEEF_93000001, 32'h108, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h9210FFFE, 32'h104, 0, 0, 0, 32'hFFFFFFFF, 32'h00007FFF);
        // load-use on rc
        drive(1, 64'h90015000, 32'h10C, 1, 4'd5, 0, 0, 0, 4'd0, 32'h0);
        step(1, 64'hDEADBEEF_93000001, 32'h108, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        drive(1, 64'h90015000, 32'h10C, 0, 4'd5, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h0, 32'h108, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        // ra hazard only for types that read ra
        drive(1, 64'hB0200000, 32'h110, 1, 4'd2, 0, 0, 0, 4'd0, 32'h0);
        step(1, 64'h90015000, 32'h10C, 0, 0, 0, 32'h2800, 32'h2800);
        drive(1, 64'h90200000, 32'h114, 1, 4'd2, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h0, 32'h10C, 0, 0, 0, 32'h2800, 32'h2800);
        // flush beats hazard
        drive(1, 64'h90015000, 32'h118, 1, 4'd5, 1, 0, 0, 4'd0, 32'h0);
        step(0, 64'h90200000, 32'h114, 0, 0, 0, 0, 0);
        drive(1, 64'h91230000, 32'h11C, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h0, 32'h114, 0, 0, 0, 0, 0);
        // downstream stall for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h9210FFFE, 32'h120, 0, 4'd0, 0, 1, 0, 4'd0, 32'h0);
            step(1, 64'h91230000, 32'h11C, 0, 32'h1234, 0, 0, 0);
        end
        drive(1, 64'h9210FFFE, 32'h120, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h91230000, 32'h11C, 0, 32'h1234, 0, 0, 0);
        drive(1, 64'h0, 32'h0, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h9210FFFE, 32'h120, 0, 0, 0, 32'hFFFFFFFF, 32'h00007FFF);
        // same-cycle writeback to ra
        drive(1, 64'h90700000, 32'h124, 0, 4'd0, 0, 0, 1, 4'd7, 32'hA5A5A5A5);
        step(0, 64'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 64'h90700000, 32'h128, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h90700000, 32'h124, BYP_A, 0, 0, 0, 0);
        drive(1, 64'h91230000, 32'h12C, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h90700000, 32'h128, 32'hA5A5A5A5, 0, 0, 0, 0);
        drive(1, 64'h91230000, 32'h12C, 0, 4'd0, 0, 1, 0, 4'd0, 32'h0);
        step(1, 64'h91230000, 32'h12C, 0, 32'h1234, 0, 0, 0);
        // asynchronous reset mid-stall
        drive(0, 64'h91230000, 32'h12C, 0, 4'd0, 0, 1, 0, 4'd0, 32'h0);
        step(0, 64'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 64'h91230000, 32'h130, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 64'h0, 32'h0, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        step(0, 64'h91230000, 32'h130, 0, 0, 0, 0, 0);

        @(negedge clk_i);
        #1;
        check("sb_drain", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
